// File: rtl/bf_round_seq_if.sv
// Block stream interface of the Blowfish round sequencer.
// Both directions use valid/ready: a transfer happens on the rising edge where
// valid and ready are both high; valid and its data hold steady until then.
interface bf_round_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_dec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, in_dec, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dec, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bf_round_seq.sv
// Iterative Blowfish round sequencer: owns the P-array and drives an external F datapath once per cycle.
// Define BF_DECRYPT_EN to build the reversed P index and decrypt whitening; otherwise in_dec is ignored.
module bf_round_seq #(
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [4:0]        key_addr,
  input  logic [31:0]       key_wdata,
  bf_round_seq_if.slave     bus,
  output logic              key_err,
  output logic [31:0]       f_in,
  input  logic [31:0]       f_out,
  output logic [1:0]        dbg_state
);
  localparam int RW = $clog2(ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [31:0]   l;
  logic [31:0]   r;
  logic [31:0]   p [18];
  logic          dec;
  logic [4:0]    k;
  logic [31:0]   t;
  logic [31:0]   wl;
  logic [31:0]   wr;
  logic          key_ok;

`ifdef BF_DECRYPT_EN
  assign k  = dec ? (5'd17 - 5'(rcnt)) : 5'(rcnt);
  assign wl = dec ? p[0] : p[17];
  assign wr = dec ? p[1] : p[16];
`else
  assign dec = 1'b0;
  assign k   = 5'(rcnt);
  assign wl  = p[17];
  assign wr  = p[16];
`endif

  // Critical path: P mux -> xor -> f_in -> external F -> xor -> l.
  assign t         = l ^ p[k];
  assign f_in      = (state == ROUND) ? t : 32'd0;
  assign key_ok    = key_we && (state == IDLE) && (key_addr <= 5'd17);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 64'd0;
      key_err       <= 1'b0;
      rcnt          <= '0;
      l             <= 32'd0;
      r             <= 32'd0;
      for (int i = 0; i < 18; i++) p[i] <= 32'd0;
`ifdef BF_DECRYPT_EN
      dec           <= 1'b0;
`endif
    end else begin
      key_err <= key_we && !key_ok;
      // A write in the accept cycle lands before round 0 reads P.
      if (key_ok) p[key_addr] <= key_wdata;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            l            <= bus.in_data[63:32];
            r            <= bus.in_data[31:0];
`ifdef BF_DECRYPT_EN
            dec          <= bus.in_dec;
`endif
            rcnt         <= '0;
            bus.in_ready <= 1'b0;
            state        <= ROUND;
          end
        end
        ROUND: begin
          l    <= r ^ f_out;
          r    <= t;
          rcnt <= rcnt + 1'b1;
          if (rcnt == RW'(ROUNDS - 1)) state <= FINAL;
        end
        FINAL: begin
          // The registers hold the swapped halves; undo the swap while whitening.
          bus.out_data  <= {r ^ wl, l ^ wr};
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_round_seq.sv
// Directed and randomized bench for bf_round_seq with a Blowfish reference model and swappable F models.
module tb_bf_round_seq;
  logic        clk;
  logic        rst;
  logic        key_we;
  logic [4:0]  key_addr;
  logic [31:0] key_wdata;
  logic        key_err;
  logic [31:0] f_in;
  logic [31:0] f_out;
  logic [1:0]  dbg_state;

  bf_round_seq_if bus ();

  bf_round_seq #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .bus       (bus),
    .key_err   (key_err),
    .f_in      (f_in),
    .f_out     (f_out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // F models: 0 -> zero, 1 -> identity, 2 -> Blowfish-style F over bench S-boxes
  int          f_mode = 0;
  logic [31:0] s0 [256];
  logic [31:0] s1 [256];
  logic [31:0] s2 [256];
  logic [31:0] s3 [256];
  logic [31:0] p_m [18];
  logic [31:0] exp_q [$];
  logic [63:0] last_out;

  assign f_out = (f_mode == 0) ? 32'd0 :
                 (f_mode == 1) ? f_in :
                 (((s0[f_in[31:24]] + s1[f_in[23:16]]) ^ s2[f_in[15:8]]) + s3[f_in[7:0]]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_ref(input logic [31:0] x);
    case (f_mode)
      0:       return 32'd0;
      1:       return x;
      default: return ((s0[x[31:24]] + s1[x[23:16]]) ^ s2[x[15:8]]) + s3[x[7:0]];
    endcase
  endfunction

  // Reference Blowfish: fills exp_q with the F operand of each round.
  task automatic ref_block(input logic [63:0] d, input bit dc, output logic [63:0] res);
    logic [31:0] xl, xr, tmp;
    bit de;
`ifdef BF_DECRYPT_EN
    de = dc;
`else
    de = 1'b0;
`endif
    xl = d[63:32];
    xr = d[31:0];
    exp_q = {};
    for (int i = 0; i < 16; i++) begin
      xl = xl ^ p_m[de ? 17 - i : i];
      exp_q.push_back(xl);
      xr = xr ^ f_ref(xl);
      tmp = xl; xl = xr; xr = tmp;
    end
    tmp = xl; xl = xr; xr = tmp;
    xr = xr ^ p_m[de ? 1 : 16];
    xl = xl ^ p_m[de ? 0 : 17];
    res = {xl, xr};
  endtask

  // drivers
  task automatic wkey(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    key_we = 1'b1; key_addr = a; key_wdata = d;
    @(posedge clk);
    #1 key_we = 1'b0;
    if (a <= 5'd17) p_m[a] = d;
  endtask

  task automatic load_p(input bit rnd);
    for (int i = 0; i < 18; i++) wkey(5'(i), rnd ? $urandom : 32'(i));
  endtask

  task automatic send(input logic [63:0] d, input bit dc, input bit kw, input logic [4:0] ka, input logic [31:0] kd);
    int n;
    @(negedge clk);
    bus.in_data = d; bus.in_dec = dc; bus.in_valid = 1'b1;
    key_we = kw; key_addr = ka; key_wdata = kd;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0; key_we = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_block(input logic [63:0] d, input bit dc, input int hold,
                           input bit kw, input logic [4:0] ka, input logic [31:0] kd);
    logic [63:0] exp;
    int n;
    if (kw && ka <= 5'd17) p_m[ka] = kd;
    ref_block(d, dc, exp);
    send(d, dc, kw, ka, kd);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("round_f_in", 64'(f_in), 64'(exp_q.pop_front()));
    end
    @(negedge clk);
    check("final_out_valid", 64'(bus.out_valid), 64'd0);
    check("final_f_in", 64'(f_in), 64'd0);
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency_extra", 64'(n), 64'd0);
    check("out_data", bus.out_data, exp);
    last_out = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", bus.out_data, exp);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    release_out();
  endtask

  initial begin
    logic [63:0] blk, enc, exp;
    int n, seen;
    rst = 1'b1; key_we = 1'b0; key_addr = '0; key_wdata = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dec = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) p_m[i] = 32'd0;
    for (int i = 0; i < 256; i++) begin
      s0[i] = $urandom; s1[i] = $urandom; s2[i] = $urandom; s3[i] = $urandom;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    check("rst_f_in", 64'(f_in), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // F = 0, P = 0: sixteen swaps cancel, the final undo-swap exchanges halves
    f_mode = 0;
    run_block(64'h0123456789ABCDEF, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    check("zero_f_swap", last_out, 64'h89ABCDEF01234567);

    // F = identity, P[k] = k
    f_mode = 1;
    load_p(1'b0);
    run_block(64'd0, 1'b0, 0, 1'b0, 5'd0, 32'd0);

    // Blowfish-style F, random P, random blocks
    f_mode = 2;
    load_p(1'b1);
    for (int i = 0; i < 3; i++) run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    blk = {$urandom, $urandom};
    run_block(blk, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    enc = last_out;
    run_block(enc, 1'b1, 0, 1'b0, 5'd0, 32'd0);
`ifdef BF_DECRYPT_EN
    check("decrypt_roundtrip", last_out, blk);
`else
    run_block(blk, 1'b1, 0, 1'b0, 5'd0, 32'd0);
    check("dec_ignored", last_out, enc);
`endif

    // key write during ROUND is rejected
    blk = {$urandom, $urandom};
    ref_block(blk, 1'b0, exp);
    exp_q = {};
    send(blk, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    key_we = 1'b1; key_addr = 5'd3; key_wdata = ~p_m[3];
    @(posedge clk);
    #1 key_we = 1'b0;
    @(negedge clk);
    check("round_key_err_hi", 64'(key_err), 64'd1);
    @(negedge clk);
    check("round_key_err_lo", 64'(key_err), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("round_key_out_valid", 64'(bus.out_valid), 64'd1);
    check("round_key_p_kept", bus.out_data, exp);
    release_out();

    // out-of-range address in IDLE is rejected; valid one raises no error
    wkey(5'd20, $urandom);
    @(negedge clk);
    check("addr20_key_err_hi", 64'(key_err), 64'd1);
    @(negedge clk);
    check("addr20_key_err_lo", 64'(key_err), 64'd0);
    wkey(5'd4, $urandom);
    @(negedge clk);
    check("valid_key_no_err", 64'(key_err), 64'd0);
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);

    // key write in the accept cycle is seen by the block
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b1, 5'd0, $urandom);

    // back-pressure, then back-to-back blocks
    run_block({$urandom, $urandom}, 1'b0, 5, 1'b0, 5'd0, 32'd0);
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);

    // reset at rcnt = 7 aborts the block and clears P
    send({$urandom, $urandom}, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 18; i++) p_m[i] = 32'd0;
    @(negedge clk);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);
    load_p(1'b1);
    run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, 5'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
